// File: rtl/mpf_vtp_port_arbiter.sv
// mpf_vtp_port_arbiter
// Shares one VTP translation port between the read- and write-channel
// translators. Requests are granted round-robin, registered toward VTP, and
// capped at MAX_OUTSTANDING in flight. In-order VTP responses are routed back
// to the issuing requester through a tag FIFO.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   rd_req_* / wr_req_*          requester channels (valid/ready handshake)
//   rd_rsp_* / wr_rsp_*          per-requester responses (no back-pressure)
//   vtp_req_*                    registered request toward VTP
//   vtp_rsp_*                    in-order responses from VTP
//   protocol_error               sticky: VTP responded with nothing in flight
//
// Optional: define MPF_VTP_ARB_STATS_EN to add saturating 32-bit grant
// counters stat_rd_grants / stat_wr_grants.
module mpf_vtp_port_arbiter #(
  parameter int ADDR_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rd_req_valid,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  input  logic                  rd_req_is_virtual,
  input  logic                  rd_req_speculative,
  output logic                  rd_req_ready,
  input  logic                  wr_req_valid,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  input  logic                  wr_req_is_virtual,
  input  logic                  wr_req_speculative,
  output logic                  wr_req_ready,
  output logic                  rd_rsp_valid,
  output logic [ADDR_WIDTH-1:0] rd_rsp_addr,
  output logic                  rd_rsp_error,
  output logic                  wr_rsp_valid,
  output logic [ADDR_WIDTH-1:0] wr_rsp_addr,
  output logic                  wr_rsp_error,
  output logic                  vtp_req_valid,
  output logic [ADDR_WIDTH-1:0] vtp_req_addr,
  output logic                  vtp_req_is_virtual,
  output logic                  vtp_req_speculative,
  input  logic                  vtp_req_ready,
  input  logic                  vtp_rsp_valid,
  input  logic [ADDR_WIDTH-1:0] vtp_rsp_addr,
  input  logic                  vtp_rsp_error,
  output logic                  protocol_error
`ifdef MPF_VTP_ARB_STATS_EN
  ,
  output logic [31:0]           stat_rd_grants,
  output logic [31:0]           stat_wr_grants
`endif
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_id_t;

  logic                  stage_valid;
  logic [ADDR_WIDTH-1:0] stage_addr;
  logic                  stage_virt;
  logic                  stage_spec;
  req_id_t               last_grant;
  logic [CW-1:0]         outstanding;
  logic [PW-1:0]         push_ptr;
  logic [PW-1:0]         pop_ptr;
  req_id_t               route_q [MAX_OUTSTANDING];
  logic                  perr_q;

  logic    stage_can_load;
  logic    can_issue;
  logic    grant_rd;
  logic    grant_wr;
  logic    accept;
  req_id_t accept_id;
  logic    fifo_empty;
  logic    rsp_ok;
  req_id_t head_id;

  always_comb begin
    stage_can_load = !stage_valid || vtp_req_ready;
    can_issue      = stage_can_load && (outstanding < MAX_CNT);
    grant_rd       = rd_req_valid && (!wr_req_valid || (last_grant == REQ_WR));
    grant_wr       = wr_req_valid && !grant_rd;
    accept         = can_issue && (grant_rd || grant_wr);
    accept_id      = grant_wr ? REQ_WR : REQ_RD;
    // The in-flight count equals FIFO occupancy, so it doubles as the empty flag.
    fifo_empty     = (outstanding == '0);
    rsp_ok         = vtp_rsp_valid && !fifo_empty;
    head_id        = route_q[pop_ptr];
  end

  assign rd_req_ready        = grant_rd && can_issue;
  assign wr_req_ready        = grant_wr && can_issue;
  assign vtp_req_valid       = stage_valid;
  assign vtp_req_addr        = stage_addr;
  assign vtp_req_is_virtual  = stage_virt;
  assign vtp_req_speculative = stage_spec;
  assign rd_rsp_valid        = rsp_ok && (head_id == REQ_RD);
  assign wr_rsp_valid        = rsp_ok && (head_id == REQ_WR);
  assign rd_rsp_addr         = vtp_rsp_addr;
  assign wr_rsp_addr         = vtp_rsp_addr;
  assign rd_rsp_error        = vtp_rsp_error;
  assign wr_rsp_error        = vtp_rsp_error;
  assign protocol_error      = perr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid <= 1'b0;
      stage_addr  <= '0;
      stage_virt  <= 1'b0;
      stage_spec  <= 1'b0;
      last_grant  <= REQ_WR;
      outstanding <= '0;
      push_ptr    <= '0;
      pop_ptr     <= '0;
      perr_q      <= 1'b0;
    end else begin
      if (stage_can_load) begin
        stage_valid <= accept;
        if (accept) begin
          stage_addr <= grant_wr ? wr_req_addr        : rd_req_addr;
          stage_virt <= grant_wr ? wr_req_is_virtual  : rd_req_is_virtual;
          stage_spec <= grant_wr ? wr_req_speculative : rd_req_speculative;
        end
      end
      if (accept) begin
        last_grant <= accept_id;
        push_ptr   <= push_ptr + PW'(1);
      end
      if (rsp_ok) begin
        pop_ptr <= pop_ptr + PW'(1);
      end
      case ({accept, rsp_ok})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      if (vtp_rsp_valid && fifo_empty) begin
        perr_q <= 1'b1;
      end
    end
  end

  // Tag storage needs no reset: entries are only read when the count says valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      route_q[push_ptr] <= accept_id;
    end
  end

`ifdef MPF_VTP_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_rd_grants <= '0;
      stat_wr_grants <= '0;
    end else begin
      if (accept && grant_rd && (stat_rd_grants != '1)) begin
        stat_rd_grants <= stat_rd_grants + 32'd1;
      end
      if (accept && grant_wr && (stat_wr_grants != '1)) begin
        stat_wr_grants <= stat_wr_grants + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mpf_vtp_port_arbiter.sv
module tb_mpf_vtp_port_arbiter;
  localparam int AW = 64;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          rd_req_valid, rd_req_is_virtual, rd_req_speculative, rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic          wr_req_valid, wr_req_is_virtual, wr_req_speculative, wr_req_ready;
  logic [AW-1:0] wr_req_addr;
  logic          rd_rsp_valid, rd_rsp_error, wr_rsp_valid, wr_rsp_error;
  logic [AW-1:0] rd_rsp_addr, wr_rsp_addr;
  logic          vtp_req_valid, vtp_req_is_virtual, vtp_req_speculative, vtp_req_ready;
  logic [AW-1:0] vtp_req_addr;
  logic          vtp_rsp_valid, vtp_rsp_error;
  logic [AW-1:0] vtp_rsp_addr;
  logic          protocol_error;
`ifdef MPF_VTP_ARB_STATS_EN
  logic [31:0]   stat_rd_grants, stat_wr_grants;
`endif

  always #5 clk = ~clk;

  mpf_vtp_port_arbiter #(
    .ADDR_WIDTH      (AW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .rd_req_valid        (rd_req_valid),
    .rd_req_addr         (rd_req_addr),
    .rd_req_is_virtual   (rd_req_is_virtual),
    .rd_req_speculative  (rd_req_speculative),
    .rd_req_ready        (rd_req_ready),
    .wr_req_valid        (wr_req_valid),
    .wr_req_addr         (wr_req_addr),
    .wr_req_is_virtual   (wr_req_is_virtual),
    .wr_req_speculative  (wr_req_speculative),
    .wr_req_ready        (wr_req_ready),
    .rd_rsp_valid        (rd_rsp_valid),
    .rd_rsp_addr         (rd_rsp_addr),
    .rd_rsp_error        (rd_rsp_error),
    .wr_rsp_valid        (wr_rsp_valid),
    .wr_rsp_addr         (wr_rsp_addr),
    .wr_rsp_error        (wr_rsp_error),
    .vtp_req_valid       (vtp_req_valid),
    .vtp_req_addr        (vtp_req_addr),
    .vtp_req_is_virtual  (vtp_req_is_virtual),
    .vtp_req_speculative (vtp_req_speculative),
    .vtp_req_ready       (vtp_req_ready),
    .vtp_rsp_valid       (vtp_rsp_valid),
    .vtp_rsp_addr        (vtp_rsp_addr),
    .vtp_rsp_error       (vtp_rsp_error),
    .protocol_error      (protocol_error)
`ifdef MPF_VTP_ARB_STATS_EN
    ,
    .stat_rd_grants      (stat_rd_grants),
    .stat_wr_grants      (stat_wr_grants)
`endif
  );

  typedef struct {
    logic          to_rd;
    logic          to_wr;
    logic [AW-1:0] addr;
    logic          err;
  } rsp_exp_t;

  rsp_exp_t exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic send_rsp(input logic to_rd, input logic to_wr,
                          input logic [AW-1:0] a, input logic e);
    rsp_exp_t x;
    x.to_rd = to_rd;
    x.to_wr = to_wr;
    x.addr  = a;
    x.err   = e;
    exp_q.push_back(x);
    vtp_rsp_valid = 1'b1;
    vtp_rsp_addr  = a;
    vtp_rsp_error = e;
  endtask

  // Response scoreboard: every VTP response has an expected entry queued.
  always @(negedge clk) begin : rsp_mon
    rsp_exp_t e;
    if (vtp_rsp_valid) begin
      chk("sb_entry_present", AW'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_rd_valid", rd_rsp_valid, e.to_rd);
        chk("rsp_wr_valid", wr_rsp_valid, e.to_wr);
        if (e.to_rd) begin
          chk("rsp_rd_addr", rd_rsp_addr, e.addr);
          chk("rsp_rd_error", rd_rsp_error, e.err);
        end
        if (e.to_wr) begin
          chk("rsp_wr_addr", wr_rsp_addr, e.addr);
          chk("rsp_wr_error", wr_rsp_error, e.err);
        end
      end
    end else begin
      chk("idle_rd_rsp_valid", rd_rsp_valid, 0);
      chk("idle_wr_rsp_valid", wr_rsp_valid, 0);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    rd_req_valid = 1'b0; rd_req_addr = '0; rd_req_is_virtual = 1'b0; rd_req_speculative = 1'b0;
    wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_is_virtual = 1'b0; wr_req_speculative = 1'b0;
    vtp_req_ready = 1'b0; vtp_rsp_valid = 1'b0; vtp_rsp_addr = '0; vtp_rsp_error = 1'b0;

    // Reset state
    mid();
    chk("rst_vtp_req_valid", vtp_req_valid, 0);
    chk("rst_protocol_error", protocol_error, 0);

    // Tie alternation into the credit limit (MO=4, no responses yet)
    cyc();
    reset_n = 1'b1; vtp_req_ready = 1'b1;
    rd_req_valid = 1'b1; rd_req_addr = 64'h100; rd_req_is_virtual = 1'b1; rd_req_speculative = 1'b0;
    wr_req_valid = 1'b1; wr_req_addr = 64'h200; wr_req_is_virtual = 1'b0; wr_req_speculative = 1'b1;
    mid();
    chk("c0_rd_ready", rd_req_ready, 1);
    chk("c0_wr_ready", wr_req_ready, 0);
    chk("c0_vtp_valid", vtp_req_valid, 0);
    cyc(); mid();
    chk("c1_rd_ready", rd_req_ready, 0);
    chk("c1_wr_ready", wr_req_ready, 1);
    chk("c1_vtp_valid", vtp_req_valid, 1);
    chk("c1_vtp_addr", vtp_req_addr, 64'h100);
    chk("c1_vtp_virt", vtp_req_is_virtual, 1);
    chk("c1_vtp_spec", vtp_req_speculative, 0);
    cyc(); mid();
    chk("c2_rd_ready", rd_req_ready, 1);
    chk("c2_wr_ready", wr_req_ready, 0);
    chk("c2_vtp_addr", vtp_req_addr, 64'h200);
    chk("c2_vtp_virt", vtp_req_is_virtual, 0);
    chk("c2_vtp_spec", vtp_req_speculative, 1);
    cyc(); mid();
    chk("c3_rd_ready", rd_req_ready, 0);
    chk("c3_wr_ready", wr_req_ready, 1);
    chk("c3_vtp_addr", vtp_req_addr, 64'h100);
    cyc(); mid();
    chk("full_rd_ready", rd_req_ready, 0);
    chk("full_wr_ready", wr_req_ready, 0);
    chk("c4_vtp_valid", vtp_req_valid, 1);
    chk("c4_vtp_addr", vtp_req_addr, 64'h200);

    // One response while full: no grant this cycle, exactly one next cycle
    cyc();
    send_rsp(1'b1, 1'b0, 64'hA0, 1'b0);
    mid();
    chk("c5_rd_ready", rd_req_ready, 0);
    chk("c5_wr_ready", wr_req_ready, 0);
    chk("c5_vtp_valid", vtp_req_valid, 0);
    cyc();
    vtp_rsp_valid = 1'b0;
    mid();
    chk("c6_rd_ready", rd_req_ready, 1);
    chk("c6_wr_ready", wr_req_ready, 0);

    // Drain in order: wr, rd, wr, rd; errors only on the wr ones
    cyc();
    send_rsp(1'b0, 1'b1, 64'hB1, 1'b1);
    mid();
    chk("c7_rd_ready", rd_req_ready, 0);
    chk("c7_wr_ready", wr_req_ready, 0);
    chk("c7_vtp_addr", vtp_req_addr, 64'h100);
    cyc();
    rd_req_valid = 1'b0; wr_req_valid = 1'b0;
    send_rsp(1'b1, 1'b0, 64'hB2, 1'b0);
    cyc();
    send_rsp(1'b0, 1'b1, 64'hB3, 1'b1);
    cyc();
    send_rsp(1'b1, 1'b0, 64'hB4, 1'b0);

    // Spurious response with nothing in flight
    cyc();
    send_rsp(1'b0, 1'b0, 64'hDEAD, 1'b1);
    mid();
    chk("sp_perr_before_edge", protocol_error, 0);

    // Back-pressure: stage one request then hold vtp_req_ready low
    cyc();
    vtp_rsp_valid = 1'b0; vtp_req_ready = 1'b0;
    rd_req_valid = 1'b1; rd_req_addr = 64'h300;
    mid();
    chk("sp_perr_set", protocol_error, 1);
    chk("bp_rd_ready", rd_req_ready, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i == 0) begin
        rd_req_addr = 64'h301; wr_req_valid = 1'b1; wr_req_addr = 64'h400;
      end
      mid();
      chk("bp_vtp_valid", vtp_req_valid, 1);
      chk("bp_vtp_addr", vtp_req_addr, 64'h300);
      chk("bp_rd_ready", rd_req_ready, 0);
      chk("bp_wr_ready", wr_req_ready, 0);
    end
    cyc();
    vtp_req_ready = 1'b1;
    mid();
    chk("bp_rel_wr_ready", wr_req_ready, 1);
    chk("bp_rel_rd_ready", rd_req_ready, 0);
    chk("bp_rel_vtp_addr", vtp_req_addr, 64'h300);
    cyc(); mid();
    chk("bp_d1_vtp_addr", vtp_req_addr, 64'h400);
    chk("bp_d1_rd_ready", rd_req_ready, 1);
    cyc();
    rd_req_valid = 1'b0; wr_req_valid = 1'b0;
    mid();
    chk("bp_d2_vtp_valid", vtp_req_valid, 1);
    chk("bp_d2_vtp_addr", vtp_req_addr, 64'h301);
    chk("sp_perr_sticky", protocol_error, 1);

    // Reset with three translations in flight and one staged
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_vtp_valid", vtp_req_valid, 0);
    chk("rst_mid_perr", protocol_error, 0);
    cyc();
    cyc();
    reset_n = 1'b1;
    rd_req_valid = 1'b1; wr_req_valid = 1'b1;
    // A fully cleared count admits a full MO accepts, rd first on the tie.
    for (int i = 0; i < MO; i++) begin
      mid();
      chk("post_rst_rd_ready", rd_req_ready, AW'((i % 2) == 0));
      chk("post_rst_wr_ready", wr_req_ready, AW'((i % 2) == 1));
      cyc();
    end
    mid();
    chk("post_rst_full_rd", rd_req_ready, 0);
    chk("post_rst_full_wr", wr_req_ready, 0);
    cyc();
    rd_req_valid = 1'b0; wr_req_valid = 1'b0;
    mid();
    chk("sb_drained", AW'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mpf_vtp_port_arbiter.md
# mpf_vtp_port_arbiter

Shares one VTP translation port between the read-channel and write-channel translators of a memory-interface shim, so that a single VTP service port covers both directions. The arbiter grants requests round-robin, registers the chosen request toward VTP, and caps the number of translations in flight. In-order VTP responses are routed back to the requester that issued them, using a tag FIFO.

## Interface
- ADDR_WIDTH, 64, translation address width (VA in, PA out)
- MAX_OUTSTANDING, 16, maximum in-flight translations and depth of the route FIFO; power of 2, ≥2
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- rd_req_valid / wr_req_valid  in  1  requester has a translation request
- rd_req_addr / wr_req_addr  in  ADDR_WIDTH  address to translate
- rd_req_is_virtual / wr_req_is_virtual  in  1  address needs translation (0 = pass-through)
- rd_req_speculative / wr_req_speculative  in  1  on a miss, return error rather than block
- rd_req_ready / wr_req_ready  out  1  request accepted this cycle when valid && ready
- rd_rsp_valid / wr_rsp_valid  out  1  response for this requester; the requester must accept it
- rd_rsp_addr / wr_rsp_addr  out  ADDR_WIDTH  translated address
- rd_rsp_error / wr_rsp_error  out  1  translation failed
- vtp_req_valid  out  1  registered request to VTP
- vtp_req_addr  out  ADDR_WIDTH  address of the registered request
- vtp_req_is_virtual  out  1  is_virtual of the registered request
- vtp_req_speculative  out  1  speculative flag of the registered request
- vtp_req_ready  in  1  VTP accepts the request
- vtp_rsp_valid  in  1  VTP response; responses are in request order
- vtp_rsp_addr  in  ADDR_WIDTH  translated address from VTP
- vtp_rsp_error  in  1  translation error from VTP
- protocol_error  out  1  sticky; VTP returned a response while the route FIFO was empty

## Operation
- **Output stage.** One register holds {addr, is_virtual, speculative} and drives the vtp_req_* outputs. It can load when it is empty or when vtp_req_valid && vtp_req_ready.
- **Credit check.** can_issue = stage can load && outstanding < MAX_OUTSTANDING, using the registered count.
- **Arbitration.** last_grant is a register that records the last requester granted.
  - Both valid: grant the requester ≠ last_grant.
  - One valid: grant it.
  - req_ready_x = grant_x && can_issue.
  - last_grant updates only on acceptance.
- **Acceptance.** On accept:
  - load the stage with the granted requester's fields;
  - push the requester ID (0 = rd, 1 = wr) into the route FIFO;
  - outstanding += 1.
- **Response routing.** When vtp_rsp_valid is high:
  - the FIFO head selects the destination requester;
  - that requester's rsp_valid goes high the same cycle, with vtp_rsp_addr and vtp_rsp_error passed through;
  - pop the FIFO and decrement outstanding.
- **Simultaneous accept and response.** Net change to outstanding is 0. The FIFO push and pop occur together.
- **Full.** When outstanding == MAX_OUTSTANDING, both req_ready are low. A response in that same cycle does not enable a grant until the next cycle.
- **Spurious response.** vtp_rsp_valid with the FIFO empty:
  - drop it (no rsp_valid, count unchanged);
  - set protocol_error until reset.
- **Idle rsp outputs.** When rsp_valid is low, rsp_addr and rsp_error are don't-care.
- **Count width.** outstanding is $clog2(MAX_OUTSTANDING)+1 bits and never wraps. The FIFO pointers wrap modulo MAX_OUTSTANDING.

## Timing
- Request latency: accept in cycle N → vtp_req_valid in cycle N+1. Full throughput is one request per cycle while vtp_req_ready stays high.
- Response latency: 0 cycles, combinational from vtp_rsp_valid to x_rsp_valid.
- Reset values (asynchronous on reset_n low):
  - vtp_req_valid = 0
  - outstanding = 0
  - FIFO empty
  - last_grant = wr, so rd wins the first tie
  - protocol_error = 0
  - all rsp_valid = 0
- Reset asserted mid-operation discards the staged request and all in-flight tags. VTP must be reset alongside the arbiter.
- vtp_req_* outputs stay stable while vtp_req_valid && !vtp_req_ready.

## Configuration
- MPF_VTP_ARB_STATS_EN defined: adds outputs stat_rd_grants and stat_wr_grants, each 32 bits.
  - Each increments on acceptance by its requester and saturates at 2^32−1.
  - Both reset to 0.
- Undefined: the stat outputs and their counters do not exist, and behaviour is otherwise identical.

## Test plan
- **Tie alternation.** rd and wr both valid continuously, vtp_req_ready=1 → accepts alternate rd, wr, rd, wr…, with rd first after reset; vtp_req_valid first rises 1 cycle after the first accept.
- **Credit limit.** MAX_OUTSTANDING=4, no responses → exactly 4 accepts, then both ready low. One response → exactly one more accept, in the following cycle.
- **Back-pressure.** vtp_req_ready=0 for 5 cycles with a request staged → vtp_req_addr is stable and no further accepts occur; raising ready drains 1 per cycle.
- **Response routing.** Issue rd A, wr B, rd C → three in-order responses yield rd_rsp_valid, wr_rsp_valid, rd_rsp_valid with the matching addr and error passed through; error=1 on B appears only on wr_rsp_error.
- **Spurious response.** vtp_rsp_valid with nothing outstanding → no rsp_valid pulses, protocol_error=1 and it stays set; deasserting reset_n clears it.
- **Reset mid-stream.** reset_n low with 3 translations outstanding → outstanding=0, vtp_req_valid=0 immediately; after reset, rd is granted first on a tie.
